mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Upstream control stage for the 2-to-1 mux datapath.
- Arbitrates between two requesting sources (A, B) and drives the mux select line.
- Issues a per-source grant, separated by a guard gap whenever select changes, so the mux output settles before the new source is told it owns the path.
- Round-robin on ties; bounded tenure when the other side is waiting.

Parameters:
- MAX_HOLD, default 16: max grant cycles while the other source is requesting; ≥1.
- GUARD_CYC, default 1: cycles with no grant after sel changes; ≥1.
- CNT_W, default $clog2(MAX_HOLD+1): hold counter width; derived, not overridden.

Ports:
- clk    in   1  rising-edge clock.
- rst_n  in   1  asynchronous active-low reset.
- req_a  in   1  source A requests mux path; held high for whole transfer.
- req_b  in   1  source B requests mux path; held high for whole transfer.
- sel    out  1  mux select; 0 = A, 1 = B; registered.
- grant_a out 1  A owns path; registered.
- grant_b out 1  B owns path; registered.
- busy   out  1  high whenever state ≠ IDLE; registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, grant_a=0, grant_b=0, busy=0, hold_cnt=0, last=B (A wins first tie). Applies mid-grant too: grants drop immediately, no guard.
- States: IDLE, GUARD, GNT_A, GNT_B. All outputs registered; grant_a and grant_b are never both high.
- IDLE:
  - Target = requester; on tie, target = not last.
  - On any request: sel←target, guard_cnt←1, go GUARD.
  - No request: stay; sel holds its previous value.
- GUARD:
  - Grants low; guard_cnt increments.
  - When guard_cnt==GUARD_CYC, go GNT_target with grant_target←1, hold_cnt←1, last←target.
  - If req_target drops during GUARD: other requesting → retarget (sel←other, guard_cnt←1, stay GUARD); else → IDLE.
  - Latency: req sampled at edge k → sel valid after k; grant high after edge k+GUARD_CYC.
- GNT_x:
  - hold_cnt increments each cycle, saturating at MAX_HOLD.
  - req_x low → grant_x←0. If other requesting → GUARD toward other (sel flips); else → IDLE with sel unchanged.
  - hold_cnt==MAX_HOLD and other requesting and req_x still high → preempt: grant_x←0, GUARD toward other.
  - hold_cnt==MAX_HOLD and other idle → stay granted, counter saturated; preempt the cycle the other requests.
  - Release and preempt on the same cycle → treated as release; same destination.
- Counter arithmetic unsigned, CNT_W bits; never wraps (saturates).
- MAX_HOLD=1 legal: preempt after one grant cycle when contended.

Test Plan:
- Reset then req_a=1 only (GUARD_CYC=1): sel=0 after first edge, grant_a=1 after second edge, busy=1 from first edge; drop req_a → grant_a=0, busy=0 next edge, sel stays 0.
- req_a=req_b=1 simultaneously after reset: A granted first; at hold_cnt=16, grant_a=0, sel=1, one guard cycle, grant_b=1; B later preempted back to A after 16 cycles, alternating indefinitely.
- Grant B alone, hold 40 cycles with req_a=0: grant_b stays high, no preempt; raise req_a at cycle 40 → grant_b=0 next edge, sel=0, grant_a=1 one edge later.
- GUARD_CYC=3, req_b pulse dropped during guard with req_a high: sel retargets to 0, guard restarts, grant_b never asserts, grant_a after 3 more edges.
- Assert rst_n=0 asynchronously mid-GNT_B: grant_b, busy, sel go 0 without clock edge; after release, tie resolves to A.
- Every cycle of every test: assertion grant_a & grant_b == 0, and sel constant while either grant high.

Source files
------------

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two mux sources and the select arbiter.
// The master side raises requests; the slave side (arbiter) drives select and grants.
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic sel;
    logic grant_a;
    logic grant_b;
    logic busy;

    modport master (
        output req_a, req_b,
        input  sel, grant_a, grant_b, busy
    );

    modport slave (
        input  req_a, req_b,
        output sel, grant_a, grant_b, busy
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select, with a guard gap
// between a select change and the new grant, and bounded tenure under contention.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned GUARD_CYC = 1,
    parameter int unsigned CNT_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_sel_arbiter_if.slave  bus
);
    localparam int unsigned GCNT_W = $clog2(GUARD_CYC + 1);

    typedef enum logic [1:0] {IDLE, GUARD, GNT_A, GNT_B} state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               grant_a_q, grant_a_d;
    logic               grant_b_q, grant_b_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GCNT_W-1:0]  guard_cnt_q, guard_cnt_d;

    logic own_req;
    logic oth_req;
    logic hold_max;

    // sel always names the current target (GUARD) or owner (GNT_x).
    assign own_req  = sel_q ? bus.req_b : bus.req_a;
    assign oth_req  = sel_q ? bus.req_a : bus.req_b;
    assign hold_max = (hold_cnt_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        grant_a_d   = grant_a_q;
        grant_b_d   = grant_b_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        guard_cnt_d = guard_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    sel_d       = (bus.req_a && bus.req_b) ? ~last_q : bus.req_b;
                    guard_cnt_d = GCNT_W'(1);
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                if (!own_req) begin
                    if (oth_req) begin
                        sel_d       = ~sel_q;
                        guard_cnt_d = GCNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (guard_cnt_q == GCNT_W'(GUARD_CYC)) begin
                    state_d    = sel_q ? GNT_B : GNT_A;
                    grant_a_d  = ~sel_q;
                    grant_b_d  = sel_q;
                    hold_cnt_d = CNT_W'(1);
                    last_d     = sel_q;
                end else begin
                    guard_cnt_d = guard_cnt_q + GCNT_W'(1);
                end
            end
            GNT_A, GNT_B: begin
                // Release and preempt share one exit; release wins only in name.
                if (!own_req || (hold_max && oth_req)) begin
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                    if (oth_req) begin
                        state_d     = GUARD;
                        sel_d       = ~sel_q;
                        guard_cnt_d = GCNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!hold_max) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                grant_a_d = 1'b0;
                grant_b_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b1;
            hold_cnt_q  <= '0;
            guard_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            grant_a_q   <= grant_a_d;
            grant_b_q   <= grant_b_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.grant_a = grant_a_q;
    assign bus.grant_b = grant_b_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scenario bench for mux_sel_arbiter: default instance plus a GUARD_CYC=3 / MAX_HOLD=1 instance.
module tb_mux_sel_arbiter;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mux_sel_arbiter_if if1();
    mux_sel_arbiter_if if2();

    mux_sel_arbiter dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    mux_sel_arbiter #(.MAX_HOLD(1), .GUARD_CYC(3)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One planned cycle: inputs to drive and expected {sel, grant_a, grant_b, busy} after the edge.
    typedef struct packed {
        logic       ra;
        logic       rb;
        logic [3:0] exp;
    } step_t;

    step_t      stim_q[$];
    logic [3:0] sb_q[$];

    function automatic void add(int n, logic ra, logic rb, logic s, logic ga, logic gb, logic bz);
        for (int i = 0; i < n; i++) stim_q.push_back('{ra, rb, {s, ga, gb, bz}});
    endfunction

    // Per-cycle invariants on both instances.
    logic p1_g, p1_s, p2_g, p2_s;
    always @(negedge clk) begin
        if (!rst_n) begin
            p1_g = 1'b0;
            p2_g = 1'b0;
        end else begin
            checks++;
            if ((if1.grant_a & if1.grant_b) !== 1'b0 || (p1_g && (if1.grant_a | if1.grant_b) && if1.sel !== p1_s)) begin
                errors++;
                $display("FAIL inv_dut1 @%0t: ga=%b gb=%b sel=%b prev_sel=%b", $time, if1.grant_a, if1.grant_b, if1.sel, p1_s);
            end
            checks++;
            if ((if2.grant_a & if2.grant_b) !== 1'b0 || (p2_g && (if2.grant_a | if2.grant_b) && if2.sel !== p2_s)) begin
                errors++;
                $display("FAIL inv_dut2 @%0t: ga=%b gb=%b sel=%b prev_sel=%b", $time, if2.grant_a, if2.grant_b, if2.sel, p2_s);
            end
            p1_g = if1.grant_a | if1.grant_b;
            p1_s = if1.sel;
            p2_g = if2.grant_a | if2.grant_b;
            p2_s = if2.sel;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        if2.req_a = 1'b0; if2.req_b = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst_n = 1'b1;
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        if2.req_a = 1'b0; if2.req_b = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
        checks++;
        if (obs !== 4'b0000) begin errors++; $display("FAIL reset_dut1: got %b want 0000", obs); end
        obs = {if2.sel, if2.grant_a, if2.grant_b, if2.busy};
        checks++;
        if (obs !== 4'b0000) begin errors++; $display("FAIL reset_dut2: got %b want 0000", obs); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
        checks++;
        if (obs !== 4'b0000) begin errors++; $display("FAIL reset_idle: got %b want 0000", obs); end
    endtask

    task automatic test_single_a();
        step_t st; logic [3:0] exp, obs; int n = 0;
        add(1, 1, 0, 0, 0, 0, 1);
        add(2, 1, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            if1.req_a = st.ra; if1.req_b = st.rb;
            sb_q.push_back(st.exp);
            @(posedge clk); #1;
            exp = sb_q.pop_front();
            obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL single_a step %0d: got %b want %b", n, obs, exp); end
            n++;
        end
    endtask

    task automatic test_tie();
        step_t st; logic [3:0] exp, obs; int n = 0;
        do_reset();
        add(1,  1, 1, 0, 0, 0, 1);
        add(16, 1, 1, 0, 1, 0, 1);
        add(1,  1, 1, 1, 0, 0, 1);
        add(16, 1, 1, 1, 0, 1, 1);
        add(1,  1, 1, 0, 0, 0, 1);
        add(4,  1, 1, 0, 1, 0, 1);
        add(1,  0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            if1.req_a = st.ra; if1.req_b = st.rb;
            sb_q.push_back(st.exp);
            @(posedge clk); #1;
            exp = sb_q.pop_front();
            obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL tie step %0d: got %b want %b", n, obs, exp); end
            n++;
        end
    endtask

    task automatic test_hold_no_contention();
        step_t st; logic [3:0] exp, obs; int n = 0;
        add(1,  0, 1, 1, 0, 0, 1);
        add(40, 0, 1, 1, 0, 1, 1);
        add(1,  1, 1, 0, 0, 0, 1);
        add(1,  1, 1, 0, 1, 0, 1);
        add(1,  0, 1, 1, 0, 0, 1);
        add(1,  0, 1, 1, 0, 1, 1);
        add(2,  0, 0, 1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            if1.req_a = st.ra; if1.req_b = st.rb;
            sb_q.push_back(st.exp);
            @(posedge clk); #1;
            exp = sb_q.pop_front();
            obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL hold_b step %0d: got %b want %b", n, obs, exp); end
            n++;
        end
    endtask

    task automatic test_async_reset();
        step_t st; logic [3:0] exp, obs; int n = 0;
        add(1, 0, 1, 1, 0, 0, 1);
        add(2, 0, 1, 1, 0, 1, 1);
        for (int phase = 0; phase < 2; phase++) begin
            while (stim_q.size() > 0) begin
                st = stim_q.pop_front();
                if1.req_a = st.ra; if1.req_b = st.rb;
                sb_q.push_back(st.exp);
                @(posedge clk); #1;
                exp = sb_q.pop_front();
                obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL async_rst step %0d: got %b want %b", n, obs, exp); end
                n++;
            end
            if (phase == 0) begin
                #2 rst_n = 1'b0;
                #1;
                obs = {if1.sel, if1.grant_a, if1.grant_b, if1.busy};
                checks++;
                if (obs !== 4'b0000) begin errors++; $display("FAIL async_rst_drop: got %b want 0000", obs); end
                if1.req_a = 1'b0; if1.req_b = 1'b0;
                #1 rst_n = 1'b1;
                add(1, 1, 1, 0, 0, 0, 1);
                add(1, 1, 1, 0, 1, 0, 1);
                add(1, 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic test_guard_retarget();
        step_t st; logic [3:0] exp, obs; int n = 0;
        add(1, 0, 1, 1, 0, 0, 1);
        add(1, 1, 1, 1, 0, 0, 1);
        add(3, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(3, 1, 1, 1, 0, 0, 1);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            if2.req_a = st.ra; if2.req_b = st.rb;
            sb_q.push_back(st.exp);
            @(posedge clk); #1;
            exp = sb_q.pop_front();
            obs = {if2.sel, if2.grant_a, if2.grant_b, if2.busy};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL guard3 step %0d: got %b want %b", n, obs, exp); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_hold_no_contention();
        test_async_reset();
        test_guard_retarget();
        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
